load_count_arbiter: RTL and testbench



---
 rtl/load_count_arbiter.sv | 112 +++++++++++
 tb/tb_load_count_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/load_count_arbiter.sv
// load_count_arbiter
//   Grants a shared 4-bit loadable up-counter to one of two requesters. The
//   winner's start value is loaded into the counter. The slot then runs until
//   the counter reaches TERM, and a one-cycle done pulse closes it. When both
//   requesters ask at once, the one that was not served last wins. After reset,
//   requester 0 has priority.
//
// Ports
//   clk        single clock, rising edge
//   reset      asynchronous, active-low reset
//   req0/req1  slot requests
//   data0/1    start values, sampled only at the grant edge
//   gnt0/gnt1  requester owns the counter (LOAD and RUN)
//   done0/1    one-cycle slot-complete pulse
//   cnt_load   load strobe to the external counter
//   cnt_data   load value; holds the last granted start value
//   cnt_count  current counter value
//   busy       high whenever the FSM is not in IDLE
//
// state | meaning
// IDLE  | waiting for a request; arbitrates on every edge
// LOAD  | cnt_load asserted for one cycle, counter takes cnt_data
// RUN   | counting; leaves when cnt_count equals TERM at an edge
// DONE  | done pulse for the winner, grants already dropped

module load_count_arbiter #(
   parameter logic [3:0] TERM = 4'd15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic [3:0] data0,
   input  logic       req1,
   input  logic [3:0] data1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       done0,
   output logic       done1,
   output logic       cnt_load,
   output logic [3:0] cnt_data,
   input  logic [3:0] cnt_count,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t state;
   logic   last_srv;   // 1: requester 1 was served last
   logic   pick1;

   // Requester 1 wins when it is alone, or when both ask and 0 was served last.
   assign pick1 = req1 & (~req0 | ~last_srv);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         gnt0     <= 1'b0;
         gnt1     <= 1'b0;
         done0    <= 1'b0;
         done1    <= 1'b0;
         cnt_load <= 1'b0;
         cnt_data <= 4'd0;
         busy     <= 1'b0;
         last_srv <= 1'b1;
      end else begin
         cnt_load <= 1'b0;
         done0    <= 1'b0;
         done1    <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  state    <= LOAD;
                  gnt0     <= ~pick1;
                  gnt1     <= pick1;
                  cnt_data <= pick1 ? data1 : data0;
                  cnt_load <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            LOAD: begin
               state <= RUN;
            end
            RUN: begin
               if (cnt_count == TERM) begin
                  state    <= DONE;
                  gnt0     <= 1'b0;
                  gnt1     <= 1'b0;
                  done0    <= gnt0;
                  done1    <= gnt1;
                  last_srv <= gnt1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               gnt0  <= 1'b0;
               gnt1  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_count_arbiter.sv
module tb_load_count_arbiter;

   localparam logic [3:0] TERM = 4'd15;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       req0 = 1'b0;
   logic [3:0] data0 = 4'd0;
   logic       req1 = 1'b0;
   logic [3:0] data1 = 4'd0;
   logic       gnt0, gnt1, done0, done1, cnt_load, busy;
   logic [3:0] cnt_data;
   logic [3:0] cnt_count = 4'd0;

   load_count_arbiter #(.TERM(TERM)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .data0(data0), .req1(req1), .data1(data1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .cnt_load(cnt_load), .cnt_data(cnt_data), .cnt_count(cnt_count),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // External 4-bit loadable up-counter: load wins, else +1 with natural wrap.
   always @(posedge clk) begin
      if (cnt_load) cnt_count <= cnt_data;
      else          cnt_count <= cnt_count + 4'd1;
   end

   int checks = 0;
   int errors = 0;

   task automatic fail(input string name, input int act, input int exp);
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) fail(name, act, exp);
   endtask

   // ---------------- reference model (transaction level) ----------------
   typedef struct {
      int who;
      int data;
      int grant_edge;
      int done_edge;
   } slot_t;

   slot_t q[$];
   int    edge_n = 0;
   int    next_free = 0;
   int    last1 = 1;
   int    exp_cnt_data = 0;
   int    m_who, m_d, m_j;

   always @(posedge clk) begin
      edge_n = edge_n + 1;
      if (reset && edge_n >= next_free && (req0 || req1)) begin
         if (req0 && req1) m_who = (last1 == 1) ? 0 : 1;
         else              m_who = req1 ? 1 : 0;
         m_d = m_who ? int'(data1) : int'(data0);
         m_j = (int'(TERM) - m_d + 16) % 16;
         q.push_back('{m_who, m_d, edge_n, edge_n + 2 + m_j});
         exp_cnt_data = m_d;
         last1 = m_who;
         next_free = edge_n + 4 + m_j;
      end
   end

   // ---------------- monitor ----------------
   logic  prev_g = 1'b0;
   logic  g_now;
   slot_t s;

   always @(negedge clk) begin
      if (reset) begin
         g_now = gnt0 | gnt1;
         checks++;
         if ((gnt0 && gnt1) || (done0 && done1) || (g_now && (done0 || done1)))
            fail("exclusive_gnt_done", {gnt0, gnt1, done0, done1}, 0);
         chk("cnt_load_one_cycle", int'(cnt_load), int'(g_now && !prev_g));
         chk("busy", int'(busy), int'(g_now | done0 | done1));
         chk("cnt_data_hold", int'(cnt_data), exp_cnt_data);
         if (g_now && !prev_g) begin
            checks++;
            if (q.size() == 0) fail("unexpected_grant", int'(gnt1), -1);
            else begin
               chk("grant_who", int'(gnt1), q[0].who);
               chk("grant_edge", edge_n, q[0].grant_edge);
            end
         end
         if (done0 || done1) begin
            checks++;
            if (q.size() == 0) fail("unexpected_done", int'(done1), -1);
            else begin
               s = q.pop_front();
               chk("done_who", int'(done1), s.who);
               chk("done_edge", edge_n, s.done_edge);
            end
         end
         prev_g = g_now;
      end else begin
         prev_g = 1'b0;
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r0, input logic [3:0] d0,
                        input logic r1, input logic [3:0] d1);
      req0 = r0; data0 = d0; req1 = r1; data1 = d1;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60 && edge_n < next_free; i++) step();
      checks++;
      if (edge_n < next_free) fail("idle_timeout", edge_n, next_free);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_gnt0"}, int'(gnt0), 0);
      chk({tag, "_gnt1"}, int'(gnt1), 0);
      chk({tag, "_done"}, int'(done0 | done1), 0);
      chk({tag, "_cnt_load"}, int'(cnt_load), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_cnt_data"}, int'(cnt_data), 0);
   endtask

   task automatic model_reset();
      q.delete();
      next_free = 0;
      last1 = 1;
      exp_cnt_data = 0;
   endtask

   initial begin
      #7;
      check_zero("reset");
      @(posedge clk); @(posedge clk);
      #3 reset = 1'b1;

      // single req0, data 11: done after E0+6
      drive(1, 4'd11, 0, 4'd0); step(); drive(0, 4'd0, 0, 4'd0);
      wait_idle();
      // req1, data 15: immediate terminal
      drive(0, 4'd0, 1, 4'd15); step(); drive(0, 4'd0, 0, 4'd0);
      wait_idle();
      // req0, data 0: full wrap
      drive(1, 4'd0, 0, 4'd0); step(); drive(0, 4'd0, 0, 4'd0);
      wait_idle();
      // data change and req drop during RUN
      drive(1, 4'd5, 0, 4'd0); step();
      step(); step();
      drive(0, 4'd9, 0, 4'd2);
      wait_idle();
      // both held: alternation
      drive(1, 4'd12, 1, 4'd13);
      for (int i = 0; i < 50; i++) step();
      drive(0, 4'd0, 0, 4'd0);
      wait_idle();

      // reset in the middle of RUN
      drive(1, 4'd0, 0, 4'd0); step(); drive(0, 4'd0, 0, 4'd0);
      step(); step(); step();
      #2 reset = 1'b0;
      model_reset();
      #1 check_zero("midrun_reset");
      step(); step();
      #3 reset = 1'b1;
      drive(1, 4'd3, 0, 4'd0); step(); drive(0, 4'd0, 0, 4'd0);
      wait_idle();

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         drive(($urandom_range(0, 3) == 0), 4'($urandom), ($urandom_range(0, 3) == 0), 4'($urandom));
         step();
      end
      drive(0, 4'd0, 0, 4'd0);
      wait_idle();
      step(); step(); step();
      chk("queue_drained", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
